// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin packet arbiter that shares one UART TX FIFO write
//            port among N_REQ byte-stream requesters. A grant is held for a
//            whole packet (closed by req_last), so bytes from different
//            sources never interleave on the serial line.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/last/data - per-requester byte stream (slice i of
//                                  req_data is [i*D_BIT +: D_BIT])
//            req_ready           - per-requester accept strobe
//            tx_full             - UART TX FIFO full
//            wr_uart, w_data     - UART TX FIFO write strobe / byte
//            grant, busy         - registered one-hot owner / in-packet flag
//            timeout_pulse       - one-cycle pulse on a forced release
// Options  : define UART_ARB_TIMEOUT_EN to build the stall counter that
//            forcibly releases a grant after TIMEOUT stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int D_BIT   = 8,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*D_BIT-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     tx_full,
    output logic                     wr_uart,
    output logic [D_BIT-1:0]         w_data,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     timeout_pulse
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]   r_owner;     // binary index of the current owner
    logic [PTR_W-1:0]   r_last_ptr;  // owner of the most recently finished packet

    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic               w_xfer;
    logic [D_BIT-1:0]   w_owner_data;

    // Round-robin search: first valid requester starting just after the
    // previous owner, wrapping modulo N_REQ (also correct for non power-of-2).
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_last_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_sel   = PTR_W'((int'(r_last_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_owner_data = req_data[r_owner*D_BIT +: D_BIT];

    // Write strobe is combinational so the FIFO takes the byte on the next
    // edge; this keeps throughput at one byte per cycle.
    assign w_xfer    = (r_state == ST_GRANT) && req_valid[r_owner] && !tx_full;
    assign wr_uart   = w_xfer;
    assign w_data    = (r_state == ST_GRANT) ? w_owner_data : '0;
    assign req_ready = ((r_state == ST_GRANT) && !tx_full) ? r_grant : '0;
    assign grant     = r_grant;
    assign busy      = (r_state == ST_GRANT);

`ifdef UART_ARB_TIMEOUT_EN
    logic [TO_W-1:0]    r_stall_cnt;
    logic               r_timeout_pulse;
    assign timeout_pulse = r_timeout_pulse;
`else
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            // Start as if the last requester just finished: requester 0 wins first.
            r_last_ptr <= PTR_W'(N_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            r_stall_cnt     <= '0;
            r_timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout_pulse <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    r_stall_cnt <= '0;
`endif
                    if (w_found) begin
                        r_grant <= N_REQ'(1) << w_sel;
                        r_owner <= w_sel;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
                        r_stall_cnt <= '0;
`endif
                        if (req_last[r_owner]) begin
                            r_last_ptr <= r_owner;
                            r_grant    <= '0;
                            r_state    <= ST_IDLE;
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (r_stall_cnt == TO_W'(TIMEOUT - 1)) begin
                        // Stalled owner: release it and rotate priority past it.
                        r_last_ptr      <= r_owner;
                        r_grant         <= '0;
                        r_state         <= ST_IDLE;
                        r_stall_cnt     <= '0;
                        r_timeout_pulse <= 1'b1;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter (N_REQ=4, D_BIT=8,
//            TIMEOUT=8). Per-requester source queues feed the DUT; expected
//            FIFO writes {grant, byte} are queued by the stimulus and checked
//            by an independent monitor on every wr_uart.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int D = 8;

    typedef struct packed {
        logic [N-1:0] g;
        logic [D-1:0] d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_last  = '0;
    logic [N*D-1:0]   req_data  = '0;
    logic [N-1:0]     req_ready;
    logic             tx_full = 1'b0;
    logic             wr_uart;
    logic [D-1:0]     w_data;
    logic [N-1:0]     grant;
    logic             busy;
    logic             timeout_pulse;

    uart_tx_arbiter #(.N_REQ(N), .D_BIT(D), .TIMEOUT(8), .TO_W(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data),
        .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           wr_count = 0;
    int           first_wr_cyc = 0;
    int           last_wr_cyc  = 0;
    logic [8:0]   src_q [N][$];   // {last, data}
    exp_t         exp_q [$];
    logic [N-1:0] fire = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source driver: handshake observed mid-cycle, head popped after the edge.
    initial begin
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_last[i]        = src_q[i][0][8];
                    req_data[i*D +: D] = src_q[i][0][7:0];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_last[i]        = 1'b0;
                    req_data[i*D +: D] = '0;
                end
            end
        end
    end

    // Monitor: every FIFO write must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_uart) begin
                if (wr_count == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {24'd0, w_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_grant", {28'd0, grant}, {28'd0, e.g});
                    check("wr_data", {24'd0, w_data}, {24'd0, e.d});
                    check("wr_ready", {28'd0, req_ready}, {28'd0, e.g});
                end
            end
        end
    end

    task automatic flush();
        for (int i = 0; i < N; i++) src_q[i].delete();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        tx_full = 1'b0;
        flush();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wr_count = 0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic expect_wr(input logic [N-1:0] g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_writes(input string name, input int n, input int max_cyc);
        int k;
        k = 0;
        while (wr_count < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (wr_count < n) check(name, wr_count, n);
    endtask

    initial begin
        int  k;
        logic seen;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", {28'd0, grant}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_wr", {31'd0, wr_uart}, 0);
        check("rst_wdata", {24'd0, w_data}, 0);
        check("rst_ready", {28'd0, req_ready}, 0);
        check("rst_topulse", {31'd0, timeout_pulse}, 0);

        // ---------------- single-byte packet ----------------
        do_reset();
        push(0, 8'hA5, 1'b1);
        expect_wr(4'b0001, 8'hA5);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t1_grant", {28'd0, grant}, 32'h1);
        check("t1_wr", {31'd0, wr_uart}, 1);
        check("t1_wdata", {24'd0, w_data}, 32'hA5);
        check("t1_ready", {28'd0, req_ready}, 32'h1);
        check("t1_busy", {31'd0, busy}, 1);
        @(negedge clk);
        check("t1_idle_busy", {31'd0, busy}, 0);
        check("t1_idle_grant", {28'd0, grant}, 0);
        wait_drain("t1_drain", 10);

        // ---------------- four simultaneous 2-byte packets ----------------
        do_reset();
        for (int i = 0; i < N; i++) begin
            push(i, 8'(i * 16), 1'b0);
            push(i, 8'(i * 16 + 1), 1'b1);
            expect_wr(4'(1 << i), 8'(i * 16));
            expect_wr(4'(1 << i), 8'(i * 16 + 1));
        end
        wait_drain("t2_drain", 60);
        check("t2_nwr", wr_count, 8);
        check("t2_span", last_wr_cyc - first_wr_cyc, 10);

        // ---------------- tx_full stall mid-packet ----------------
        do_reset();
        push(0, 8'hB0, 1'b0);
        push(0, 8'hB1, 1'b0);
        push(0, 8'hB2, 1'b1);
        expect_wr(4'b0001, 8'hB0);
        expect_wr(4'b0001, 8'hB1);
        expect_wr(4'b0001, 8'hB2);
        wait_writes("t3_first", 1, 20);
        @(posedge clk); #1;
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_wr", {31'd0, wr_uart}, 0);
            check("t3_stall_ready", {28'd0, req_ready}, 0);
            check("t3_stall_grant", {28'd0, grant}, 32'h1);
        end
        @(posedge clk); #1;
        tx_full = 1'b0;
        wait_drain("t3_drain", 20);
        check("t3_nwr", wr_count, 3);

        // ---------------- fairness against a streaming requester ----------------
        do_reset();
        for (int p = 0; p < 3; p++) begin
            push(1, 8'(8'h11 + 2 * p), 1'b0);
            push(1, 8'(8'h12 + 2 * p), 1'b1);
        end
        expect_wr(4'b0010, 8'h11);
        expect_wr(4'b0010, 8'h12);
        expect_wr(4'b0100, 8'h2A);
        expect_wr(4'b0100, 8'h2B);
        expect_wr(4'b0010, 8'h13);
        expect_wr(4'b0010, 8'h14);
        expect_wr(4'b0010, 8'h15);
        expect_wr(4'b0010, 8'h16);
        wait_writes("t4_first", 1, 20);
        push(2, 8'h2A, 1'b0);
        push(2, 8'h2B, 1'b1);
        wait_drain("t4_drain", 60);

        // ---------------- stalled owner / timeout ----------------
        do_reset();
        push(0, 8'hC0, 1'b0);
        push(3, 8'h3D, 1'b1);
        expect_wr(4'b0001, 8'hC0);
`ifdef UART_ARB_TIMEOUT_EN
        expect_wr(4'b1000, 8'h3D);
        wait_writes("t5_first", 1, 20);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            seen = timeout_pulse;
        end
        check("t5_to_delay", k, 9);
        check("t5_pulse_grant", {28'd0, grant}, 0);
        @(negedge clk);
        check("t5_new_grant", {28'd0, grant}, 32'h8);
        check("t5_pulse_width", {31'd0, timeout_pulse}, 0);
        wait_drain("t5_drain", 20);
`else
        wait_writes("t5_first", 1, 20);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (timeout_pulse) seen = 1'b1;
        end
        check("t5_held_grant", {28'd0, grant}, 32'h1);
        check("t5_held_busy", {31'd0, busy}, 1);
        check("t5_no_pulse", {31'd0, seen}, 0);
        wait_drain("t5_drain", 5);
`endif

        // ---------------- reset mid-packet ----------------
        do_reset();
        push(1, 8'h1E, 1'b1);
        expect_wr(4'b0010, 8'h1E);
        wait_drain("t6_pre_drain", 20);
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        expect_wr(4'b0100, 8'h20);
        wait_writes("t6_first", 2, 20);
        @(posedge clk); #1;
        rst = 1'b1;
        tx_full = 1'b1;
        @(posedge clk); #2;
        flush();
        rst = 1'b0;
        tx_full = 1'b0;
        @(negedge clk);
        check("t6_rst_grant", {28'd0, grant}, 0);
        check("t6_rst_busy", {31'd0, busy}, 0);
        check("t6_rst_wr", {31'd0, wr_uart}, 0);
        check("t6_rst_ready", {28'd0, req_ready}, 0);
        check("t6_rst_wdata", {24'd0, w_data}, 0);
        push(0, 8'h0E, 1'b1);
        push(2, 8'h2E, 1'b1);
        expect_wr(4'b0001, 8'h0E);
        expect_wr(4'b0100, 8'h2E);
        wait_drain("t6_drain", 20);
        check("t6_nwr", wr_count, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
